dec_frame_assembler: RTL and testbench

Serial-to-parallel codeword assembler that sits directly upstream of the Hamming decoder (DEC).
- Collects a serial bitstream into one codeword of 8, 16 or 32 bits, chosen by mod.
- Tags each codeword with its mode and buffers it in a small FIFO.
- Presents it to the decoder over a valid/ready handshake, with the MSBs above the codeword length zero-padded.

---
 rtl/dec_pkg.sv | 32 +++
 rtl/dec_frame_assembler_if.sv | 24 ++
 rtl/dec_frame_fifo.sv | 79 +++++++
 rtl/dec_frame_assembler.sv | 164 ++++++++++++++++
 tb/tb_dec_frame_assembler.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dec_pkg.sv
// Shared types and helpers for the DEC frame assembler.
package dec_pkg;

    typedef enum logic [1:0] {
        MOD_8   = 2'b00,
        MOD_16  = 2'b01,
        MOD_32  = 2'b10,
        MOD_ILL = 2'b11
    } mode_t;

    localparam int unsigned LEN_MOD_1 = 8;
    localparam int unsigned LEN_MOD_2 = 16;
    localparam int unsigned LEN_MOD_3 = 32;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Codeword length in bits for a mode; 0 for the illegal encoding.
    function automatic int unsigned cw_len(mode_t m);
        int unsigned len;
        case (m)
            MOD_8:   len = LEN_MOD_1;
            MOD_16:  len = LEN_MOD_2;
            MOD_32:  len = LEN_MOD_3;
            default: len = 0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/dec_frame_assembler_if.sv
// Serial-in / codeword-out bundle of the DEC frame assembler.
// master: bit source and codeword consumer; slave: the assembler.
interface dec_frame_assembler_if #(
    parameter int unsigned MAX_CODEWORD_WIDTH = 32
) ();
    logic                          bit_in;
    logic                          bit_valid;
    logic [1:0]                    mod;
    logic                          frame_abort;
    logic [MAX_CODEWORD_WIDTH-1:0] cw_out;
    logic [1:0]                    cw_mod;
    logic                          cw_valid;
    logic                          cw_ready;

    modport master (
        output bit_in, bit_valid, mod, frame_abort, cw_ready,
        input  cw_out, cw_mod, cw_valid
    );

    modport slave (
        input  bit_in, bit_valid, mod, frame_abort, cw_ready,
        output cw_out, cw_mod, cw_valid
    );
endinterface

// File: rtl/dec_frame_fifo.sv
// Synchronous FIFO of {codeword, mode} entries. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module dec_frame_fifo
    import dec_pkg::*;
#(
    parameter int unsigned CW_WIDTH = 32,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push_i,
    input  logic [CW_WIDTH-1:0] push_cw_i,
    input  mode_t               push_mod_i,
    input  logic                pop_i,
    output logic [CW_WIDTH-1:0] head_cw_o,
    output mode_t               head_mod_o,
    output logic                full_o,
    output logic                empty_o
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW_WIDTH-1:0] cw_mem_q  [DEPTH];
    logic [CW_WIDTH-1:0] cw_mem_d  [DEPTH];
    mode_t               mod_mem_q [DEPTH];
    mode_t               mod_mem_d [DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]       count_q, count_d;
    logic                do_push;
    logic                do_pop;

    // Occupancy, handshake qualification and pointer/storage next state.
    always_comb begin
        full_o    = (count_q == (PtrW + 1)'(DEPTH));
        empty_o   = (count_q == '0);
        do_pop    = pop_i && !empty_o;
        do_push   = push_i && (!full_o || do_pop);
        cw_mem_d  = cw_mem_q;
        mod_mem_d = mod_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push) begin
            cw_mem_d[wr_ptr_q]  = push_cw_i;
            mod_mem_d[wr_ptr_q] = push_mod_i;
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
        head_cw_o  = empty_o ? '0 : cw_mem_q[rd_ptr_q];
        head_mod_o = empty_o ? MOD_8 : mod_mem_q[rd_ptr_q];
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        cw_mem_q  <= cw_mem_d;
        mod_mem_q <= mod_mem_d;
    end

endmodule

// File: rtl/dec_frame_assembler.sv
// Serial-to-parallel codeword assembler feeding the Hamming decoder.
// Bits arrive LSB first; a completed word is registered for one cycle and
// then pushed into a small FIFO presented over valid/ready.
// Optional build macro DEC_FRAME_STATS_EN adds frame_cnt / drop_cnt ports.
module dec_frame_assembler
    import dec_pkg::*;
#(
    parameter int unsigned MAX_CODEWORD_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH         = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    dec_frame_assembler_if.slave  bus,
    output logic                  busy,
    output logic                  mod_err,
    output logic                  ovf
`ifdef DEC_FRAME_STATS_EN
    ,
    output logic [15:0]           frame_cnt,
    output logic [7:0]            drop_cnt
`endif
);
    state_t                        state_q, state_d;
    logic [4:0]                    cnt_q, cnt_d;
    logic [MAX_CODEWORD_WIDTH-1:0] shift_q, shift_d;
    mode_t                         cur_mod_q, cur_mod_d;
    logic                          push_pend_q, push_pend_d;
    logic                          mod_err_q, mod_err_d;
    logic                          ovf_q, ovf_d;
    mode_t                         in_mod;

    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          fifo_pop;
    logic                          push_done;
    logic [MAX_CODEWORD_WIDTH-1:0] head_cw;
    mode_t                         head_mod;

    // Assembler FSM: latch mode on the first bit, fill LSB first, flag completion.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        cur_mod_d   = cur_mod_q;
        push_pend_d = 1'b0;
        mod_err_d   = 1'b0;
        in_mod      = mode_t'(bus.mod);
        if (bus.frame_abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (bus.bit_valid) begin
            case (state_q)
                IDLE: begin
                    if (in_mod == MOD_ILL) begin
                        mod_err_d = 1'b1;
                    end else begin
                        cur_mod_d  = in_mod;
                        shift_d    = '0;
                        shift_d[0] = bus.bit_in;
                        cnt_d      = 5'd1;
                        state_d    = COLLECT;
                    end
                end
                COLLECT: begin
                    shift_d[cnt_q] = bus.bit_in;
                    if (32'(cnt_q) == cw_len(cur_mod_q) - 1) begin
                        state_d     = IDLE;
                        cnt_d       = '0;
                        push_pend_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // The completed word stays in shift_q during the push cycle: a new frame's
    // first bit is only sampled at the end of that cycle.
    always_comb begin
        fifo_pop  = bus.cw_ready && !fifo_empty;
        ovf_d     = push_pend_q && fifo_full && !fifo_pop;
        push_done = push_pend_q && !ovf_d;
    end

    // FSM, datapath and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            cur_mod_q   <= MOD_8;
            push_pend_q <= 1'b0;
            mod_err_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            cur_mod_q   <= cur_mod_d;
            push_pend_q <= push_pend_d;
            mod_err_q   <= mod_err_d;
            ovf_q       <= ovf_d;
        end
    end

    dec_frame_fifo #(
        .CW_WIDTH (MAX_CODEWORD_WIDTH),
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push_pend_q),
        .push_cw_i  (shift_q),
        .push_mod_i (cur_mod_q),
        .pop_i      (bus.cw_ready),
        .head_cw_o  (head_cw),
        .head_mod_o (head_mod),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Output mapping.
    always_comb begin
        bus.cw_out   = head_cw;
        bus.cw_mod   = head_mod;
        bus.cw_valid = !fifo_empty;
        busy         = (state_q == COLLECT);
        mod_err      = mod_err_q;
        ovf          = ovf_q;
    end

`ifdef DEC_FRAME_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    // Frame counter wraps; drop counter saturates.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (push_done) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (ovf_d && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
        frame_cnt = frame_cnt_q;
        drop_cnt  = drop_cnt_q;
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_dec_frame_assembler.sv
// Bench for dec_frame_assembler: directed scenarios plus randomized frames,
// checked against a queue-based scoreboard of expected codewords.
module tb_dec_frame_assembler;
    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic [31:0] w;
        logic [1:0]  m;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, mod_err, ovf;
`ifdef DEC_FRAME_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  drop_cnt;
`endif

    dec_frame_assembler_if #(.MAX_CODEWORD_WIDTH(W)) bus ();

    dec_frame_assembler #(
        .MAX_CODEWORD_WIDTH (W),
        .FIFO_DEPTH         (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .mod_err   (mod_err),
        .ovf       (ovf)
`ifdef DEC_FRAME_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    int   exp_ovf = 0, ovf_seen = 0;
    int   exp_moderr = 0, moderr_seen = 0;
    int   exp_frames = 0, exp_drops = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input logic [1:0] m, input logic ab);
        bus.bit_in      = b;
        bus.bit_valid   = 1'b1;
        bus.mod         = m;
        bus.frame_abort = ab;
        tick();
        bus.bit_in      = 1'b0;
        bus.bit_valid   = 1'b0;
        bus.frame_abort = 1'b0;
    endtask

    // Model of a completed frame: kept if there is room or a consumer, else dropped.
    task automatic record_completion(input logic [1:0] m, input logic [31:0] w);
        exp_t e;
        if (!bus.cw_ready && exp_q.size() >= DEPTH) begin
            exp_ovf++;
            exp_drops = (exp_drops < 255) ? exp_drops + 1 : 255;
        end else begin
            e.w = w;
            e.m = m;
            exp_q.push_back(e);
            exp_frames++;
        end
    endtask

    // Send one frame of 8<<m bits, LSB first; optional abort at bit abort_at
    // and optional mode change to m2 after bit sw_after.
    task automatic send_frame(input logic [1:0] m, input logic [31:0] w, input int abort_at,
                              input int sw_after, input logic [1:0] m2);
        int          l;
        logic [63:0] wide;
        logic [1:0]  mm;
        logic        ab;
        l    = 8 << m;
        wide = {32'h0, w} & ((64'd1 << l) - 64'd1);
        for (int k = 0; k < l; k++) begin
            mm = (sw_after >= 0 && k > sw_after) ? m2 : m;
            ab = (k == abort_at);
            drive_bit(wide[k], mm, ab);
            if (ab) break;
        end
        if (abort_at < 0) record_completion(m, wide[31:0]);
    endtask

    // Scoreboard monitor: compares the FIFO head with the model, retires on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (ovf === 1'b1) ovf_seen++;
            if (mod_err === 1'b1) moderr_seen++;
            if (bus.cw_valid === 1'b1) begin
                check("valid_with_expected_word", 64'(bus.cw_valid), 64'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    check("cw_out", 64'(bus.cw_out), 64'(exp_q[0].w));
                    check("cw_mod", 64'(bus.cw_mod), 64'(exp_q[0].m));
                    if (bus.cw_ready === 1'b1) void'(exp_q.pop_front());
                end
            end else begin
                check("cw_out_zero_when_empty", 64'(bus.cw_out), 64'd0);
                check("cw_mod_zero_when_empty", 64'(bus.cw_mod), 64'd0);
            end
        end
    end

    initial begin
        int          ab_at, sw_at, gap;
        logic [1:0]  m, m2;
        logic [31:0] w;

        bus.bit_in      = 1'b0;
        bus.bit_valid   = 1'b0;
        bus.mod         = 2'b00;
        bus.frame_abort = 1'b0;
        bus.cw_ready    = 1'b1;

        // Reset state.
        repeat (3) tick();
        rst = 1'b0;
        check("rst_cw_valid", 64'(bus.cw_valid), 64'd0);
        check("rst_cw_out", 64'(bus.cw_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mod_err", 64'(mod_err), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
`ifdef DEC_FRAME_STATS_EN
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif

        // 8-bit frame 1,0,1,1,0,0,1,0 -> 0x4D, with latency check.
        drive_bit(1'b1, 2'b00, 1'b0);
        check("busy_after_first_bit", 64'(busy), 64'd1);
        drive_bit(1'b0, 2'b00, 1'b0);
        drive_bit(1'b1, 2'b00, 1'b0);
        drive_bit(1'b1, 2'b00, 1'b0);
        drive_bit(1'b0, 2'b00, 1'b0);
        drive_bit(1'b0, 2'b00, 1'b0);
        drive_bit(1'b1, 2'b00, 1'b0);
        drive_bit(1'b0, 2'b00, 1'b0);
        record_completion(2'b00, 32'h4D);
        check("latency_not_yet_valid", 64'(bus.cw_valid), 64'd0);
        check("busy_after_last_bit", 64'(busy), 64'd0);
        tick();
        check("latency_valid", 64'(bus.cw_valid), 64'd1);
        check("first_word", 64'(bus.cw_out), 64'h4D);
        tick();
        check("drained_after_pop", 64'(bus.cw_valid), 64'd0);

        // 32-bit frame with mid-frame mode change ignored.
        send_frame(2'b10, 32'hDEADBEEF, -1, 5, 2'b01);
        repeat (2) tick();

        // Abort on the final bit of a 16-bit frame, then a zero frame.
        send_frame(2'b01, 32'h0000FFFF, 15, -1, 2'b00);
        check("abort_busy", 64'(busy), 64'd0);
        send_frame(2'b01, 32'h00000000, -1, -1, 2'b00);
        repeat (3) tick();

        // Overflow: three back-to-back frames with consumer stalled.
        bus.cw_ready = 1'b0;
        send_frame(2'b00, 32'h11, -1, -1, 2'b00);
        send_frame(2'b00, 32'h22, -1, -1, 2'b00);
        send_frame(2'b00, 32'h33, -1, -1, 2'b00);
        tick();
        check("ovf_pulse", 64'(ovf), 64'd1);
        tick();
        check("ovf_one_cycle", 64'(ovf), 64'd0);
        check("stalled_head", 64'(bus.cw_out), 64'h11);
`ifdef DEC_FRAME_STATS_EN
        check("frame_cnt", 64'(frame_cnt), 64'(exp_frames));
        check("drop_cnt", 64'(drop_cnt), 64'(exp_drops));
`endif
        bus.cw_ready = 1'b1;
        repeat (3) tick();
        check("ovf_drained", 64'(bus.cw_valid), 64'd0);

        // Illegal mode on a first bit.
        drive_bit(1'b1, 2'b11, 1'b0);
        exp_moderr++;
        check("mod_err_pulse", 64'(mod_err), 64'd1);
        check("mod_err_busy", 64'(busy), 64'd0);
        tick();
        check("mod_err_one_cycle", 64'(mod_err), 64'd0);
        check("mod_err_no_push", 64'(bus.cw_valid), 64'd0);
        send_frame(2'b01, 32'h0000A5C3, -1, -1, 2'b00);
        repeat (3) tick();

        // Reset mid-frame.
        for (int k = 0; k < 5; k++) drive_bit(1'b1, 2'b00, 1'b0);
        check("busy_mid_frame", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_frames = 0;
        exp_drops  = 0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_cw_valid", 64'(bus.cw_valid), 64'd0);
        check("midrst_cw_out", 64'(bus.cw_out), 64'd0);
`ifdef DEC_FRAME_STATS_EN
        check("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
        send_frame(2'b00, 32'hFF, -1, -1, 2'b00);
        tick();
        check("after_rst_word", 64'(bus.cw_out), 64'hFF);
        repeat (2) tick();

        // Randomized frames with gaps, aborts, mode changes and illegal first bits.
        for (int i = 0; i < 30; i++) begin
            m     = 2'($urandom_range(0, 2));
            w     = $urandom;
            ab_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, (8 << m) - 1)) : -1;
            sw_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
            m2    = 2'($urandom_range(0, 3));
            send_frame(m, w, ab_at, sw_at, m2);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 3) == 0) begin
                    drive_bit(1'($urandom), 2'b11, 1'b0);
                    exp_moderr++;
                end else begin
                    tick();
                end
            end
        end
        repeat (5) tick();

        check("all_words_delivered", 64'(exp_q.size()), 64'd0);
        check("ovf_total", 64'(ovf_seen), 64'(exp_ovf));
        check("mod_err_total", 64'(moderr_seen), 64'(exp_moderr));
`ifdef DEC_FRAME_STATS_EN
        check("final_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
        check("final_drop_cnt", 64'(drop_cnt), 64'(exp_drops));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
